// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I decode stage with a halt FSM.
// Define IDU_PIPE_CSR_EN to decode SYSTEM CSR ops as legal.
module idu_pipe #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_opcode,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_ebreak,
  output logic            out_ecall,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_irq_no,
  output logic [11:0]     out_csr_addr,
  output logic            halted
);

  localparam bit RV64 = (XLEN == 64);
`ifdef IDU_PIPE_CSR_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6f;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_IMM32 = 7'h1b;
  localparam logic [6:0] OPC_OP32  = 7'h3b;
  localparam logic [6:0] OPC_FENCE = 7'h0f;
  localparam logic [6:0] OPC_SYS   = 7'h73;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic            mem_rd;
    logic            mem_wr;
    logic            ebreak;
    logic            ecall;
    logic            illegal;
    logic [XLEN-1:0] irq_no;
    logic [11:0]     csr_addr;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_HALT
  } state_t;

  state_t state_q, state_d;
  dec_t   q, d;
  logic   load;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_load, is_store, is_imm;
  logic is_op, is_imm32, is_op32, is_fence;
  logic is_sys, is_i, is_ebreak, is_ecall;
  logic is_csr, bad_f7, w_f3_ok, ill;
  logic rs1_use, rs2_use;
  logic [XLEN-1:0] imm;

  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BR;
  assign is_load  = opc == OPC_LOAD;
  assign is_store = opc == OPC_STORE;
  assign is_imm   = opc == OPC_IMM;
  assign is_op    = opc == OPC_OP;
  assign is_imm32 = opc == OPC_IMM32;
  assign is_op32  = opc == OPC_OP32;
  assign is_fence = opc == OPC_FENCE;
  assign is_sys   = opc == OPC_SYS;

  assign is_i = is_jalr | is_load | is_imm
              | is_imm32 | is_fence | is_sys;

  assign is_ebreak = in_inst == 32'h0010_0073;
  assign is_ecall  = in_inst == 32'h0000_0073;
  assign is_csr    = is_sys && f3 != 3'd0
                  && f3 != 3'd4;

  // funct7 may only be 0x20 on ADD/SUB and SRL/SRA slots
  assign bad_f7 = f7 != 7'h00
               && !(f7 == 7'h20
               && (f3 == 3'd0 || f3 == 3'd5));
  assign w_f3_ok = f3 == 3'd0 || f3 == 3'd1
                || f3 == 3'd5;

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_i:     imm = {{(XLEN-11){in_inst[31]}},
                       in_inst[30:20]};
      is_store: imm = {{(XLEN-11){in_inst[31]}},
                       in_inst[30:25], in_inst[11:7]};
      is_br:    imm = {{(XLEN-12){in_inst[31]}},
                       in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
      is_lui,
      is_auipc: imm = {{(XLEN-31){in_inst[31]}},
                       in_inst[30:12], 12'b0};
      is_jal:   imm = {{(XLEN-20){in_inst[31]}},
                       in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
      default:  imm = '0;
    endcase
  end

  always_comb begin
    ill = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc,
      is_jal, is_fence: ill = 1'b0;
      is_jalr:  ill = f3 != 3'd0;
      is_br:    ill = f3[2:1] == 2'b01;
      is_load:  ill = f3 == 3'd7 || (!RV64
                   && (f3 == 3'd3 || f3 == 3'd6));
      is_store: ill = f3[2] || (!RV64 && f3 == 3'd3);
      is_imm:   ill = (f3 == 3'd1
                   && (in_inst[31:26] != 6'd0
                   || (!RV64 && in_inst[25])))
                   || (f3 == 3'd5 && (in_inst[31]
                   || in_inst[29:26] != 4'd0
                   || (!RV64 && in_inst[25])));
      is_op:    ill = bad_f7;
      is_imm32: ill = !RV64 || !w_f3_ok
                   || (f3 != 3'd0 && bad_f7);
      is_op32:  ill = !RV64 || !w_f3_ok || bad_f7;
      is_sys:   ill = (f3 == 3'd0
                   && !(is_ecall || is_ebreak))
                   || f3 == 3'd4
                   || (is_csr && !CSR_EN);
      default:  ill = 1'b1;
    endcase
  end

  // CSRRxI forms carry a zimm in the rs1 slot
  assign rs1_use = !(is_lui || is_auipc || is_jal)
                && !(is_sys && f3[2]);
  assign rs2_use = is_br || is_store
                || is_op || is_op32;

  always_comb begin
    d         = '0;
    d.pc      = in_pc;
    d.rs1     = rs1_use ? in_inst[19:15] : 5'd0;
    d.rs2     = rs2_use ? in_inst[24:20] : 5'd0;
    d.rd_wen  = !ill && !(is_br || is_store)
             && !(is_sys && f3 == 3'd0);
    d.rd      = d.rd_wen ? in_inst[11:7] : 5'd0;
    d.imm     = imm;
    d.funct3  = f3;
    d.opcode  = opc;
    d.mem_rd  = is_load && !ill;
    d.mem_wr  = is_store && !ill;
    d.ebreak  = is_ebreak;
    d.ecall   = is_ecall;
    d.illegal = ill;
    d.irq_no  = is_ecall ? XLEN'(11) : '0;
`ifdef IDU_PIPE_CSR_EN
    d.csr_addr = is_csr ? in_inst[31:20] : 12'd0;
`else
    d.csr_addr = 12'd0;
`endif
  end

  logic accept, trap;
  assign in_ready = rst_n && state_q != S_HALT
                 && !flush
                 && (state_q != S_FULL || out_ready);
  assign accept   = in_valid && in_ready;
  assign trap     = q.ebreak || q.illegal;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_FULL;
          load    = 1'b1;
        end
      end
      S_FULL: begin
        if (flush) begin
          state_d = S_EMPTY;
        end else if (out_ready && trap) begin
          state_d = S_HALT;
        end else if (accept) begin
          load = 1'b1;
        end else if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      q       <= '0;
    end else begin
      state_q <= state_d;
      if (load) q <= d;
    end
  end

  assign out_valid    = state_q == S_FULL;
  assign halted       = state_q == S_HALT;
  assign out_pc       = q.pc;
  assign out_rs1      = q.rs1;
  assign out_rs2      = q.rs2;
  assign out_rd       = q.rd;
  assign out_rd_wen   = q.rd_wen;
  assign out_imm      = q.imm;
  assign out_funct3   = q.funct3;
  assign out_opcode   = q.opcode;
  assign out_mem_rd   = q.mem_rd;
  assign out_mem_wr   = q.mem_wr;
  assign out_ebreak   = q.ebreak;
  assign out_ecall    = q.ecall;
  assign out_illegal  = q.illegal;
  assign out_irq_no   = q.irq_no;
  assign out_csr_addr = q.csr_addr;

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: XLEN=32 and XLEN=64 instances on shared stimulus,
// checked against a rule-level decode model and handshake model.
module tb_idu_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] imm;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        mrd;
    logic        mwr;
    logic        eb;
    logic        ec;
    logic        ill;
    logic [63:0] irq;
    logic [11:0] csr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic a_rdy, a_vld, a_rwen, a_mrd, a_mwr;
  logic a_eb, a_ec, a_ill, a_hlt;
  logic [31:0] a_pc, a_imm, a_irq;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [2:0] a_f3;
  logic [6:0] a_op;
  logic [11:0] a_csr;

  logic b_rdy, b_vld, b_rwen, b_mrd, b_mwr;
  logic b_eb, b_ec, b_ill, b_hlt;
  logic [31:0] b_pc;
  logic [63:0] b_imm, b_irq;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [2:0] b_f3;
  logic [6:0] b_op;
  logic [11:0] b_csr;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .PC_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_rdy),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(a_vld), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rd(a_rd), .out_rd_wen(a_rwen), .out_imm(a_imm),
    .out_funct3(a_f3), .out_opcode(a_op),
    .out_mem_rd(a_mrd), .out_mem_wr(a_mwr),
    .out_ebreak(a_eb), .out_ecall(a_ec),
    .out_illegal(a_ill), .out_irq_no(a_irq),
    .out_csr_addr(a_csr), .halted(a_hlt));

  idu_pipe #(.XLEN(64), .PC_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_rdy),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(b_vld), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd(b_rd), .out_rd_wen(b_rwen), .out_imm(b_imm),
    .out_funct3(b_f3), .out_opcode(b_op),
    .out_mem_rd(b_mrd), .out_mem_wr(b_mwr),
    .out_ebreak(b_eb), .out_ecall(b_ec),
    .out_illegal(b_ill), .out_irq_no(b_irq),
    .out_csr_addr(b_csr), .halted(b_hlt));

  rec_t got0, got1;
  assign got0 = {a_pc, a_rs1, a_rs2, a_rd, a_rwen,
                 32'b0, a_imm, a_f3, a_op, a_mrd, a_mwr,
                 a_eb, a_ec, a_ill, 32'b0, a_irq, a_csr};
  assign got1 = {b_pc, b_rs1, b_rs2, b_rd, b_rwen,
                 b_imm, b_f3, b_op, b_mrd, b_mwr,
                 b_eb, b_ec, b_ill, b_irq, b_csr};

  int   n_checks = 0;
  int   n_err = 0;
  bit   m_valid [2];
  bit   m_halt [2];
  rec_t m_rec [2];
  int   n_acc [2];
  int   dut_hs [2];

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic rec_t ref_dec(input logic [31:0] w,
                                   input logic [31:0] pc,
                                   input bit x64);
    rec_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    byte fmt;
    bit ill, sys0, wen, csr_on, f7ok;
    logic [63:0] imm;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
`ifdef IDU_PIPE_CSR_EN
    csr_on = 1'b1;
`else
    csr_on = 1'b0;
`endif
    case (op)
      7'h37, 7'h17: fmt = "U";
      7'h6f: fmt = "J";
      7'h63: fmt = "B";
      7'h23: fmt = "S";
      7'h33, 7'h3b: fmt = "R";
      7'h67, 7'h03, 7'h13, 7'h1b, 7'h0f, 7'h73: fmt = "I";
      default: fmt = "X";
    endcase
    case (fmt)
      "I": imm = 64'($signed(w[31:20]));
      "S": imm = 64'($signed({w[31:25], w[11:7]}));
      "B": imm = 64'($signed({w[31], w[7], w[30:25],
                              w[11:8], 1'b0}));
      "U": imm = 64'($signed({w[31:12], 12'b0}));
      "J": imm = 64'($signed({w[31], w[19:12], w[20],
                              w[30:21], 1'b0}));
      default: imm = 64'd0;
    endcase
    sys0 = (op == 7'h73) && (f3 == 3'd0);
    f7ok = (f7 == 7'h00)
        || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    case (op)
      7'h37, 7'h17, 7'h6f, 7'h0f: ill = 1'b0;
      7'h67: ill = (f3 != 3'd0);
      7'h63: ill = (f3 == 3'd2 || f3 == 3'd3);
      7'h03: ill = (f3 == 3'd7)
                || (!x64 && (f3 == 3'd3 || f3 == 3'd6));
      7'h23: ill = (f3 > 3'd3) || (!x64 && f3 == 3'd3);
      7'h13: begin
        if (f3 == 3'd1)
          ill = (w[31:26] != 6'd0) || (!x64 && w[25]);
        else if (f3 == 3'd5)
          ill = !(w[31:26] == 6'd0 || w[31:26] == 6'h10)
             || (!x64 && w[25]);
        else
          ill = 1'b0;
      end
      7'h33: ill = !f7ok;
      7'h1b: ill = !x64
                || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)
                || (f3 == 3'd1 && f7 != 7'h00)
                || (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
      7'h3b: ill = !x64
                || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)
                || !f7ok;
      7'h73: ill = sys0 ? (w != 32'h73 && w != 32'h00100073)
                        : (f3 == 3'd4 || !csr_on);
      default: ill = 1'b1;
    endcase
    wen = !ill && fmt != "S" && fmt != "B" && !sys0;
    r.pc  = pc;
    r.rs1 = (op == 7'h37 || op == 7'h17 || op == 7'h6f
          || (op == 7'h73 && f3 >= 3'd4)) ? 5'd0 : w[19:15];
    r.rs2 = (op == 7'h63 || op == 7'h23 || op == 7'h33
          || op == 7'h3b) ? w[24:20] : 5'd0;
    r.rd  = wen ? w[11:7] : 5'd0;
    r.wen = wen;
    r.imm = x64 ? imm : {32'b0, imm[31:0]};
    r.f3  = f3;
    r.op  = op;
    r.mrd = (op == 7'h03) && !ill;
    r.mwr = (op == 7'h23) && !ill;
    r.eb  = (w == 32'h00100073);
    r.ec  = (w == 32'h00000073);
    r.ill = ill;
    r.irq = r.ec ? 64'd11 : 64'd0;
    r.csr = (op == 7'h73 && !sys0 && !ill) ? w[31:20] : 12'd0;
    return r;
  endfunction

  task automatic step(input bit rst, input bit fl,
                      input bit iv, input logic [31:0] w,
                      input logic [31:0] pc, input bit ordy);
    bit er, gr, gv;
    rst_n = rst;
    flush = fl;
    in_valid = iv;
    in_inst = w;
    in_pc = pc;
    out_ready = ordy;
    #1;
    for (int i = 0; i < 2; i++) begin
      er = rst && !m_halt[i] && !fl && (!m_valid[i] || ordy);
      gr = (i == 0) ? a_rdy : b_rdy;
      gv = (i == 0) ? a_vld : b_vld;
      check($sformatf("in_ready%0d", i), gr, er);
      if (rst && !fl && gv && ordy) dut_hs[i]++;
      if (!rst) begin
        m_valid[i] = 1'b0;
        m_halt[i]  = 1'b0;
        m_rec[i]   = '0;
      end else if (!m_halt[i]) begin
        if (fl) begin
          m_valid[i] = 1'b0;
        end else if (m_valid[i] && ordy
                     && (m_rec[i].eb || m_rec[i].ill)) begin
          m_halt[i]  = 1'b1;
          m_valid[i] = 1'b0;
        end else if (iv && er) begin
          m_rec[i]   = ref_dec(w, pc, i == 1);
          m_valid[i] = 1'b1;
          n_acc[i]++;
        end else if (ordy) begin
          m_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("valid32", a_vld, m_valid[0]);
    check("valid64", b_vld, m_valid[1]);
    check("halted32", a_hlt, m_halt[0]);
    check("halted64", b_hlt, m_halt[1]);
    check("rec32", got0, m_rec[0]);
    check("rec64", got1, m_rec[1]);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [12];
    logic [31:0] w;
    int r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h73};
    w = $urandom;
    case ($urandom_range(0, 15))
      0: return 32'h00100073;
      1: return 32'h00000073;
      2: return w;
      default: begin
        w[6:0] = ops[$urandom_range(0, 11)];
        r = $urandom_range(0, 3);
        if (r == 0) w[31:25] = 7'h00;
        else if (r == 1) w[31:25] = 7'h20;
        return w;
      end
    endcase
  endfunction

  int base, hs0, hcnt;
  bit pat [4];

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = '0;
    in_pc = '0;
    out_ready = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    step(0, 0, 1, 32'hFFF10093, 32'h4, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rdy_after_rst", a_rdy, 1'b1);

    step(1, 0, 1, 32'hFFF10093, 32'h100, 1);
    check("addi_valid", a_vld, 1'b1);
    check("addi_rd", got0.rd, 5'd1);
    check("addi_rs1", got0.rs1, 5'd2);
    check("addi_rs2", got0.rs2, 5'd0);
    check("addi_imm32", a_imm, 32'hFFFF_FFFF);
    check("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_wen", a_rwen, 1'b1);

    step(1, 0, 1, 32'h00512423, 32'h104, 1);
    check("sw_rs1", a_rs1, 5'd2);
    check("sw_rs2", a_rs2, 5'd5);
    check("sw_rd", a_rd, 5'd0);
    check("sw_wen", a_rwen, 1'b0);
    check("sw_imm", a_imm, 32'd8);
    check("sw_memwr", a_mwr, 1'b1);

    step(1, 0, 0, 0, 0, 1);
    base = n_acc[0];
    hs0 = dut_hs[0];
    for (int c = 0; c < 40 && (n_acc[0] - base) < 4; c++) begin
      int k;
      k = n_acc[0] - base;
      step(1, 0, 1, {12'(k + 1), 5'd0, 3'd0, 5'(k + 1), 7'h13},
           32'h200 + 32'(4 * k), pat[c % 4]);
    end
    for (int c = 0; c < 4; c++) step(1, 0, 0, 0, 0, 1);
    check("stream_hs", dut_hs[0] - hs0, 4);

    step(1, 0, 1, 32'h00100073, 32'h300, 0);
    check("ebrk_full", a_eb, 1'b1);
    step(1, 1, 0, 0, 0, 0);
    check("flush_valid", a_vld, 1'b0);
    check("flush_nohalt", a_hlt, 1'b0);
    step(1, 0, 1, 32'h00100073, 32'h304, 0);
    step(1, 0, 1, 32'hFFF10093, 32'h308, 1);
    check("ebrk_halt", a_hlt, 1'b1);
    step(1, 1, 1, 32'hFFF10093, 32'h30c, 1);
    check("halt_rdy", a_rdy, 1'b0);
    check("halt_stay", b_hlt, 1'b1);

    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h02009093, 32'h400, 0);
    check("slli_ill32", a_ill, 1'b1);
    check("slli_ok64", b_ill, 1'b0);
    check("slli_imm64", b_imm, 64'd32);
    step(1, 0, 0, 0, 0, 1);
    check("slli_halt32", a_hlt, 1'b1);
    check("slli_run64", b_hlt, 1'b0);
    step(1, 0, 1, 32'hFFF10093, 32'h404, 1);
    check("slli_rdy32", a_rdy, 1'b0);

    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h30002173, 32'h500, 0);
`ifdef IDU_PIPE_CSR_EN
    check("csr_addr", a_csr, 12'h300);
    check("csr_rd", a_rd, 5'd2);
    check("csr_legal", a_ill, 1'b0);
    step(1, 0, 0, 0, 0, 1);
    check("csr_nohalt", a_hlt, 1'b0);
`else
    check("csr_ill", a_ill, 1'b1);
    check("csr_addr0", a_csr, 12'h000);
    step(1, 0, 0, 0, 0, 1);
    check("csr_halt", a_hlt, 1'b1);
`endif

    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      if (m_halt[0] || m_halt[1]) hcnt++;
      else hcnt = 0;
      r = (hcnt <= 3) && ($urandom_range(0, 199) != 0);
      step(r, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, rnd_inst(),
           $urandom, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
